if_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV pipeline. It owns the program counter and issues in-order fetch requests over a valid/ready instruction-memory port. It buffers returned instruction words in a 2-entry queue and drives the registered `ifid_t` bundle (`instr`, `PC`, `PCPlus4`) consumed by decode. It handles execute-stage redirects by discarding in-flight responses and inserting bubbles.

---
 rtl/if_stage.sv | 204 ++++++++++++++++++++
 tb/tb_if_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses and drives IF/ID.
// Optional macro IFETCH_PERF_EN adds the fetch_count / drop_count event counters.
`timescale 1ns/1ps

package if_stage_pkg;
    localparam int IFID_XLEN = 32;

    typedef struct packed {
        logic [31:0]          instr;
        logic [IFID_XLEN-1:0] PC;
        logic [IFID_XLEN-1:0] PCPlus4;
    } ifid_t;
endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter int              XLEN     = IFID_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output ifid_t           outputs,
    output logic            ValidD
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     drop_count
`endif
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam ifid_t       BUBBLE = '{instr: NOP, PC: '0, PCPlus4: '0};

    function automatic ifid_t make_entry(input logic [31:0] instr, input logic [XLEN-1:0] pc_in);
        ifid_t e;
        e.instr   = instr;
        e.PC      = pc_in;
        e.PCPlus4 = pc_in + XLEN'(4);
        return e;
    endfunction

    logic [XLEN-1:0] pc;
    logic [1:0]      inflight;
    logic [1:0]      discard;
    logic            tag_rd;
    logic            tag_wr;
    logic [XLEN-1:0] tag_pc [2];

    logic [1:0]      occ;
    logic            fifo_rd;
    logic            fifo_wr;
    logic [31:0]     fifo_instr [2];
    logic [XLEN-1:0] fifo_pc    [2];

    ifid_t           ifid_p1;
    logic            vld_p1;

    logic            pop;
    logic [2:0]      credit_used;
    logic            req_fire;
    logic            rsp_ok;
    logic            drop;
    logic            push;
    logic            bypass;
    logic            fifo_push;
    logic [1:0]      inflight_after_rsp;
    logic [XLEN-1:0] rsp_pc;

    // Request credits cover every word that may still land: in flight plus buffered.
    always_comb begin
        pop                = (occ != 2'd0) && !StallD && !FlushD;
        credit_used        = {1'b0, inflight} + {1'b0, occ} - {2'b00, pop};
        imem_req_valid     = reset && !PCSrcE && (credit_used < 3'd2);
        req_fire           = imem_req_valid && imem_req_ready;
        rsp_ok             = imem_rsp_valid && (inflight != 2'd0);
        drop               = rsp_ok && ((discard != 2'd0) || PCSrcE);
        push               = rsp_ok && !drop;
        bypass             = push && (occ == 2'd0) && !StallD && !FlushD;
        fifo_push          = push && !bypass;
        inflight_after_rsp = inflight - {1'b0, rsp_ok};
        rsp_pc             = tag_pc[tag_rd];
    end

    assign imem_req_addr = pc;

    // ---- stage p0: PC, request tracking and stale-response discard ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            inflight <= 2'd0;
            discard  <= 2'd0;
            tag_rd   <= 1'b0;
            tag_wr   <= 1'b0;
        end else begin
            if (PCSrcE)
                pc <= PCTargetE;
            else if (req_fire)
                pc <= pc + XLEN'(4);

            inflight <= inflight_after_rsp + {1'b0, req_fire};

            if (PCSrcE)
                discard <= inflight_after_rsp;
            else if (drop && (discard != 2'd0))
                discard <= discard - 2'd1;

            if (req_fire)
                tag_wr <= !tag_wr;
            if (rsp_ok)
                tag_rd <= !tag_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            tag_pc[tag_wr] <= pc;
    end

    // Two-entry response queue; a redirect empties it in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ     <= 2'd0;
            fifo_rd <= 1'b0;
            fifo_wr <= 1'b0;
        end else if (PCSrcE) begin
            occ     <= 2'd0;
            fifo_rd <= 1'b0;
            fifo_wr <= 1'b0;
        end else begin
            occ <= occ + {1'b0, fifo_push} - {1'b0, pop};
            if (fifo_push)
                fifo_wr <= !fifo_wr;
            if (pop)
                fifo_rd <= !fifo_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_instr[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]    <= rsp_pc;
        end
    end

    // ---- stage p1: IF/ID register (empty queue lets the response bypass straight in) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_p1 <= BUBBLE;
            vld_p1  <= 1'b0;
        end else if (FlushD || PCSrcE) begin
            ifid_p1 <= BUBBLE;
            vld_p1  <= 1'b0;
        end else if (StallD) begin
            ifid_p1 <= ifid_p1;
            vld_p1  <= vld_p1;
        end else if (occ != 2'd0) begin
            ifid_p1 <= make_entry(fifo_instr[fifo_rd], fifo_pc[fifo_rd]);
            vld_p1  <= 1'b1;
        end else if (push) begin
            ifid_p1 <= make_entry(imem_rsp_data, rsp_pc);
            vld_p1  <= 1'b1;
        end else begin
            ifid_p1 <= BUBBLE;
            vld_p1  <= 1'b0;
        end
    end

    assign outputs = ifid_p1;
    assign ValidD  = vld_p1;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 32'd0;
            drop_count  <= 32'd0;
        end else begin
            if (push)
                fetch_count <= fetch_count + 32'd1;
            if (drop)
                drop_count <= drop_count + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_rsp_without_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && (inflight == 2'd0)));
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
        ({1'b0, inflight} + {1'b0, occ}) <= 3'd2);
    a_discard_bound: assert property (@(posedge clk) disable iff (!reset)
        discard <= inflight);
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall backpressure, flush, redirect drop, PC wrap, async reset.
`timescale 1ns/1ps

module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    ifid_t       outputs;
    logic        ValidD;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .outputs        (outputs),
        .ValidD         (ValidD)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];

    localparam logic [95:0] BUBBLE_V = {32'h0000_0013, 32'h0, 32'h0};

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h0050_0193;
    endfunction

    function automatic logic [95:0] ent(input logic [31:0] a);
        return {word(a), a, a + 32'd4};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    // One clock: note the handshake before the edge, update the memory model after it.
    task automatic step();
        logic        fire;
        logic        taken;
        logic [31:0] fa;
        #1;
        fire  = imem_req_valid && imem_req_ready;
        fa    = imem_req_addr;
        taken = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (taken) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (fire) begin
            q_addr.push_back(fa);
            q_due.push_back(cyc + lat);
        end
        cyc++;
        drive_rsp();
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        PCSrcE         = 1'b0;
        q_addr.delete();
        q_due.delete();
        #1;
        chk({tag, "_ifid"}, outputs, BUBBLE_V);
        chk({tag, "_validd"}, ValidD, 1'b0);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
`ifdef IFETCH_PERF_EN
        chk({tag, "_fetch_count"}, fetch_count, 32'd0);
        chk({tag, "_drop_count"}, drop_count, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        do_reset("rst0");

        // Streaming with a 1-cycle memory
        #1;
        chk("c0_req_valid", imem_req_valid, 1'b1);
        chk("c0_req_addr", imem_req_addr, 32'h100);
        step();
        #1;
        chk("c1_req_addr", imem_req_addr, 32'h104);
        chk("c1_validd", ValidD, 1'b0);
        step();
        #1;
        chk("c2_ifid", outputs, {32'h0050_0093, 32'h100, 32'h104});
        chk("c2_validd", ValidD, 1'b1);
        chk("c2_req_addr", imem_req_addr, 32'h108);
        step();
        #1;
        chk("c3_ifid", outputs, ent(32'h104));

        // Stall for cycles 4..7
        step();
        StallD = 1'b1;
        #1;
        chk("c4_ifid", outputs, ent(32'h108));
        step();
        #1;
        chk("c5_req_valid", imem_req_valid, 1'b0);
        step();
        #1;
        chk("c6_req_valid", imem_req_valid, 1'b0);
        chk("c6_ifid_frozen", outputs, ent(32'h108));
        step();
        #1;
        chk("c7_ifid_frozen", outputs, ent(32'h108));
        chk("c7_validd", ValidD, 1'b1);
        step();
        StallD = 1'b0;
        #1;
        chk("c8_req_valid", imem_req_valid, 1'b1);
        chk("c8_req_addr", imem_req_addr, 32'h114);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk($sformatf("resume_%0d", k), outputs, ent(32'h10C + 32'(4 * k)));
        end

        // FlushD together with StallD at cycle 13
        step();
        FlushD = 1'b1;
        StallD = 1'b1;
        #1;
        chk("c13_ifid", outputs, ent(32'h11C));
        chk("c13_req_valid", imem_req_valid, 1'b0);
        step();
        FlushD = 1'b0;
        StallD = 1'b0;
        #1;
        chk("c14_bubble", outputs, BUBBLE_V);
        chk("c14_validd", ValidD, 1'b0);
        chk("c14_req_addr", imem_req_addr, 32'h128);
        step();
        #1;
        chk("c15_head_kept", outputs, ent(32'h120));
        chk("c15_validd", ValidD, 1'b1);
        step();
        #1;
        chk("c16_ifid", outputs, ent(32'h124));

        // Asynchronous reset mid-stream, then redirect with a 3-cycle memory
        lat = 3;
        do_reset("rst1");
        #1;
        chk("r1c0_req_addr", imem_req_addr, 32'h100);
        step();
        #1;
        chk("r1c1_req_valid", imem_req_valid, 1'b1);
        chk("r1c1_req_addr", imem_req_addr, 32'h104);
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        #1;
        chk("r1c2_req_valid", imem_req_valid, 1'b0);
        step();
        PCSrcE = 1'b0;
        #1;
        chk("r1c3_req_valid", imem_req_valid, 1'b0);
        chk("r1c3_validd", ValidD, 1'b0);
        step();
        #1;
        chk("r1c4_req_valid", imem_req_valid, 1'b1);
        chk("r1c4_req_addr", imem_req_addr, 32'h200);
        chk("r1c4_validd", ValidD, 1'b0);
        for (int k = 5; k < 8; k++) begin
            step();
            #1;
            chk($sformatf("r1c%0d_validd", k), ValidD, 1'b0);
        end
        step();
        #1;
        chk("r1c8_ifid", outputs, ent(32'h200));
        chk("r1c8_validd", ValidD, 1'b1);
`ifdef IFETCH_PERF_EN
        chk("r1c8_drop_count", drop_count, 32'd2);
        chk("r1c8_fetch_count", fetch_count, 32'd1);
`endif

        // Redirect to the top of the address space and wrap
        lat = 1;
        do_reset("rst2");
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        #1;
        chk("r2c1_req_valid", imem_req_valid, 1'b0);
        step();
        PCSrcE = 1'b0;
        #1;
        chk("r2c2_req_valid", imem_req_valid, 1'b1);
        chk("r2c2_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("r2c2_validd", ValidD, 1'b0);
        step();
        #1;
        chk("r2c3_req_addr", imem_req_addr, 32'h0);
        chk("r2c3_validd", ValidD, 1'b0);
        step();
        #1;
        chk("r2c4_ifid", outputs, {32'hFFAF_FE6F, 32'hFFFF_FFFC, 32'h0});
        chk("r2c4_validd", ValidD, 1'b1);
        step();
        #1;
        chk("r2c5_ifid", outputs, {32'h0050_0193, 32'h0, 32'h4});
`ifdef IFETCH_PERF_EN
        chk("r2c5_drop_count", drop_count, 32'd1);
        chk("r2c5_fetch_count", fetch_count, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
